// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the generic inter-stage pipeline register: occupancy
// encoding and default counter width.
package pipe_stage_skid_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   localparam int STALL_CNTW_DEFAULT = 16;

   function automatic logic occ_full(input occ_e o);
      return (o == OCC_TWO);
   endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the perf counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         cpu_clk_50M,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge cpu_clk_50M) begin
      if (clear)
         count <= '0;
      else if (enable && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int            DW      = 32,
   parameter logic [DW-1:0] RST_VAL = '0,
   parameter int            SKID    = 1,
   parameter int            CNTW    = STALL_CNTW_DEFAULT
) (
   input  logic            cpu_clk_50M,
   input  logic            cpu_rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [1:0]      occ,
   output logic [CNTW-1:0] stall_cycles
);

   occ_e          occ_q, occ_nxt;
   logic [DW-1:0] main_q, main_nxt;
   logic [DW-1:0] skid_q, skid_nxt;
   logic          accept, drain;

   assign out_valid = (occ_q != OCC_EMPTY);
   assign out_data  = (occ_q == OCC_EMPTY) ? RST_VAL : main_q;
   assign occ       = occ_q;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Main entry always feeds the output; skid only fills when main is stalled.
   always_comb begin
      occ_nxt  = occ_q;
      main_nxt = main_q;
      skid_nxt = skid_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (accept) begin
               main_nxt = in_data;
               occ_nxt  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && drain) begin
               main_nxt = in_data;
            end else if (drain) begin
               occ_nxt = OCC_EMPTY;
            end else if (accept && (SKID != 0)) begin
               skid_nxt = in_data;
               occ_nxt  = OCC_TWO;
            end
         end
         OCC_TWO: begin
            if (drain) begin
               main_nxt = skid_q;
               occ_nxt  = OCC_ONE;
            end
         end
         default: occ_nxt = OCC_EMPTY;
      endcase
      if (flush) begin
         occ_nxt  = OCC_EMPTY;
         main_nxt = RST_VAL;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         occ_q  <= OCC_EMPTY;
         main_q <= RST_VAL;
      end else begin
         occ_q  <= occ_nxt;
         main_q <= main_nxt;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      skid_q <= skid_nxt;
   end

   // Skid variant registers in_ready so no combinational path from out_ready.
   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_q;
         always_ff @(posedge cpu_clk_50M) begin
            if (cpu_rst)
               in_ready_q <= 1'b1;
            else
               in_ready_q <= !occ_full(occ_nxt);
         end
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   sat_counter #(
      .W(CNTW)
   ) u_stall_cnt (
      .cpu_clk_50M(cpu_clk_50M),
      .clear      (cpu_rst),
      .enable     (out_valid && !out_ready),
      .count      (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: three instances (skid, no-skid,
// 4-bit stall counter) checked every cycle against a queue-based model.
module tb_pipe_stage_skid;

   localparam int          N = 3;
   localparam logic [31:0] RST_VALS  [N] = '{32'h0000_0013, 32'h0000_0000, 32'hFFFF_FFFF};
   localparam int          SKIDS     [N] = '{1, 0, 1};
   localparam int          STALL_MAX [N] = '{65535, 65535, 15};

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst;
   logic        flush_s     [N];
   logic        in_valid_s  [N];
   logic [31:0] in_data_s   [N];
   logic        out_ready_s [N];
   logic        src_en      [N];

   logic        in_ready_w  [N];
   logic        out_valid_w [N];
   logic [31:0] out_data_w  [N];
   logic [1:0]  occ_w       [N];
   logic [15:0] stall_w     [N];
   logic [3:0]  stall_c;

   logic [31:0] send_q [N][$];
   logic [31:0] exp_q  [N][$];
   int          stall_m [N];
   logic        ready_m [N];
   bit          started = 1'b0;
   int          checks  = 0;
   int          errors  = 0;

   always #10 cpu_clk_50M = ~cpu_clk_50M;

   pipe_stage_skid #(.DW(32), .RST_VAL(32'h0000_0013), .SKID(1), .CNTW(16)) dut_a (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush_s[0]),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]), .in_data(in_data_s[0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .out_data(out_data_w[0]),
      .occ(occ_w[0]), .stall_cycles(stall_w[0]));

   pipe_stage_skid #(.DW(32), .RST_VAL(32'h0000_0000), .SKID(0), .CNTW(16)) dut_b (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush_s[1]),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]), .in_data(in_data_s[1]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .out_data(out_data_w[1]),
      .occ(occ_w[1]), .stall_cycles(stall_w[1]));

   pipe_stage_skid #(.DW(32), .RST_VAL(32'hFFFF_FFFF), .SKID(1), .CNTW(4)) dut_c (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush_s[2]),
      .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]), .in_data(in_data_s[2]),
      .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]), .out_data(out_data_w[2]),
      .occ(occ_w[2]), .stall_cycles(stall_c));

   assign stall_w[2] = {12'd0, stall_c};

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d] got %h expected %h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // Upstream presents the head of its send queue; then one clock elapses.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         for (int i = 0; i < N; i++) begin
            in_valid_s[i] = src_en[i] && (send_q[i].size() != 0);
            in_data_s[i]  = (send_q[i].size() != 0) ? send_q[i][0] : 32'h0BAD_0BAD;
         end
         @(posedge cpu_clk_50M);
         #1;
      end
   endtask

   task automatic setAll(input bit ordy, input bit fl, input bit en);
      for (int i = 0; i < N; i++) begin
         out_ready_s[i] = ordy;
         flush_s[i]     = fl;
         src_en[i]      = en;
      end
   endtask

   task automatic pushAll(input logic [31:0] d);
      for (int i = 0; i < N; i++) send_q[i].push_back(d);
   endtask

   // Monitor: compare DUT against the model, then book this cycle's transfers.
   always @(negedge cpu_clk_50M) begin
      int          sz;
      logic        exp_rdy;
      logic [31:0] exp_data;
      for (int i = 0; i < N; i++) begin
         sz       = exp_q[i].size();
         exp_rdy  = (SKIDS[i] != 0) ? ready_m[i] : ((sz == 0) || out_ready_s[i]);
         exp_data = (sz != 0) ? exp_q[i][0] : RST_VALS[i];
         if (started) begin
            checkOutput("out_valid", i, {31'd0, out_valid_w[i]}, {31'd0, sz != 0});
            checkOutput("out_data", i, out_data_w[i], exp_data);
            checkOutput("occ", i, {30'd0, occ_w[i]}, sz);
            checkOutput("in_ready", i, {31'd0, in_ready_w[i]}, {31'd0, exp_rdy});
            checkOutput("stall_cycles", i, {16'd0, stall_w[i]}, stall_m[i]);
         end
         if (cpu_rst) begin
            exp_q[i].delete();
            stall_m[i] = 0;
            ready_m[i] = 1'b1;
         end else if (started) begin
            if ((sz != 0) && !out_ready_s[i] && (stall_m[i] < STALL_MAX[i]))
               stall_m[i]++;
            if ((sz != 0) && out_ready_s[i])
               void'(exp_q[i].pop_front());
            if (in_valid_s[i] && exp_rdy) begin
               void'(send_q[i].pop_front());
               if (!flush_s[i]) exp_q[i].push_back(in_data_s[i]);
            end
            if (flush_s[i]) exp_q[i].delete();
            ready_m[i] = (exp_q[i].size() < 2);
         end
      end
      if (cpu_rst) started = 1'b1;
   end

   initial begin
      cpu_rst = 1'b1;
      setAll(1'b0, 1'b0, 1'b1);
      pushAll(32'hDEAD_BEEF);
      applyStimulus(2);
      for (int i = 0; i < N; i++) send_q[i].delete();
      applyStimulus(1);
      cpu_rst = 1'b0;
      applyStimulus(2);

      $display("[TB] streaming 0x1..0x8");
      setAll(1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) pushAll(k);
      applyStimulus(12);

      $display("[TB] back-pressure A,B,C");
      setAll(1'b0, 1'b0, 1'b1);
      pushAll(32'hA); pushAll(32'hB); pushAll(32'hC);
      applyStimulus(5);
      setAll(1'b1, 1'b0, 1'b1);
      applyStimulus(6);

      $display("[TB] flush at full occupancy");
      setAll(1'b0, 1'b0, 1'b1);
      pushAll(32'hD); pushAll(32'hE);
      applyStimulus(4);
      pushAll(32'hF);
      setAll(1'b0, 1'b1, 1'b1);
      applyStimulus(1);
      for (int i = 0; i < N; i++) send_q[i].delete();
      setAll(1'b0, 1'b0, 1'b1);
      applyStimulus(3);

      $display("[TB] stall counter saturation");
      pushAll(32'h55);
      applyStimulus(22);
      setAll(1'b1, 1'b0, 1'b1);
      applyStimulus(3);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            out_ready_s[i] = ($urandom_range(0, 9) < 6);
            flush_s[i]     = ($urandom_range(0, 39) == 0);
            src_en[i]      = ($urandom_range(0, 4) != 0);
            if ((send_q[i].size() < 3) && ($urandom_range(0, 1) == 1))
               send_q[i].push_back($urandom);
         end
         applyStimulus(1);
      end
      setAll(1'b1, 1'b0, 1'b1);
      applyStimulus(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
